// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - register file read/write/issue bus with scoreboard status
interface reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            we;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            stall;
  logic [AW:0]     pending_cnt;

  modport master (
    output rs1_addr, rs2_addr, we, rd_addr, rd_data, issue_valid, issue_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, pending_cnt
  );

  modport slave (
    input  rs1_addr, rs2_addr, we, rd_addr, rd_data, issue_valid, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, pending_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - RV32I register file with pending-write scoreboard
module reg_file_sb #(
  parameter int              XLEN      = 32,
  parameter int              NREGS     = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0,
  parameter int              BYPASS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pending;
  logic [AW:0]      r_cnt;

  logic             w_wr_ok;
  logic             w_issue_ok;
  logic             w_byp1;
  logic             w_byp2;
  logic             w_inc;
  logic             w_dec;
  logic [NREGS-1:0] w_pend_nxt;

  // Qualify the write and issue requests; x0 is never a real destination.
  always_comb begin
    w_wr_ok    = bus.we && (bus.rd_addr != '0);
    w_issue_ok = bus.issue_valid && (bus.issue_rd != '0);
    // Forwarding is suppressed in reset so reads show the reset image only.
    w_byp1     = (BYPASS != 0) && !rst && w_wr_ok && (bus.rd_addr == bus.rs1_addr);
    w_byp2     = (BYPASS != 0) && !rst && w_wr_ok && (bus.rd_addr == bus.rs2_addr);
  end

  // Combinational read ports with optional write-back forwarding.
  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (bus.rs1_addr != '0) bus.rs1_data = w_byp1 ? bus.rd_data : r_regs[bus.rs1_addr];
    if (bus.rs2_addr != '0) bus.rs2_data = w_byp2 ? bus.rd_data : r_regs[bus.rs2_addr];
  end

  // Busy flags: a forwarded write-back this cycle already satisfies the operand.
  always_comb begin
    bus.rs1_busy    = r_pending[bus.rs1_addr] && !w_byp1;
    bus.rs2_busy    = r_pending[bus.rs2_addr] && !w_byp2;
    bus.stall       = bus.rs1_busy || bus.rs2_busy;
    bus.pending_cnt = r_cnt;
  end

  // Next scoreboard image: clear on write-back first, then a new issue sets (set wins).
  always_comb begin
    w_pend_nxt = r_pending;
    if (bus.we) w_pend_nxt[bus.rd_addr] = 1'b0;
    if (w_issue_ok) w_pend_nxt[bus.issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
    // Count only bits that actually change state so the counter tracks popcount.
    w_inc = w_issue_ok && !r_pending[bus.issue_rd];
    w_dec = bus.we && r_pending[bus.rd_addr] && !w_pend_nxt[bus.rd_addr];
  end

  // Architectural register storage; x0 is held at zero and never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= (i == 0) ? '0 : RESET_VAL;
    end else if (w_wr_ok) begin
      r_regs[bus.rd_addr] <= bus.rd_data;
    end
  end

  // Scoreboard bits and their population counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_cnt     <= r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  reg_file_sb_if #(.XLEN(32), .AW(5)) bus_a ();
  reg_file_sb_if #(.XLEN(32), .AW(5)) bus_b ();

  reg_file_sb #(.BYPASS(1)) u_dut    (.clk(clk), .rst(rst), .bus(bus_a));
  reg_file_sb #(.BYPASS(0)) u_dut_nb (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.rs1_addr    = bus_a.rs1_addr;
  assign bus_b.rs2_addr    = bus_a.rs2_addr;
  assign bus_b.we          = bus_a.we;
  assign bus_b.rd_addr     = bus_a.rd_addr;
  assign bus_b.rd_data     = bus_a.rd_data;
  assign bus_b.issue_valid = bus_a.issue_valid;
  assign bus_b.issue_rd    = bus_a.issue_rd;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus_a.rs1_addr = '0; bus_a.rs2_addr = '0;
    bus_a.we = 1'b0; bus_a.rd_addr = '0; bus_a.rd_data = '0;
    bus_a.issue_valid = 1'b0; bus_a.issue_rd = '0;
    #12;
    chk("rst_cnt", 32'(bus_a.pending_cnt), 0);
    rst = 1'b0;
    tick();

    // 1: reset image
    for (int i = 0; i < 32; i++) begin
      bus_a.rs1_addr = 5'(i);
      bus_a.rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("rst_rs1_x%0d", i), bus_a.rs1_data, 0);
      chk($sformatf("rst_rs2_x%0d", 31 - i), bus_a.rs2_data, 0);
      chk("rst_busy", {30'd0, bus_a.rs1_busy, bus_a.rs2_busy}, 0);
    end
    chk("rst_stall", 32'(bus_a.stall), 0);
    chk("rst_cnt2", 32'(bus_a.pending_cnt), 0);

    // 2: plain writes, x0 discard
    bus_a.we = 1'b1; bus_a.rd_addr = 5'd1; bus_a.rd_data = 32'd415;
    tick();
    bus_a.rd_addr = 5'd2; bus_a.rd_data = 32'd60;
    tick();
    bus_a.we = 1'b0; bus_a.rs1_addr = 5'd1; bus_a.rs2_addr = 5'd2;
    #1;
    chk("wr_x1", bus_a.rs1_data, 32'd415);
    chk("wr_x2", bus_a.rs2_data, 32'd60);
    chk("wr_cnt", 32'(bus_a.pending_cnt), 0);
    bus_a.we = 1'b1; bus_a.rd_addr = 5'd0; bus_a.rd_data = 32'hDEADBEEF; bus_a.rs1_addr = 5'd0;
    #1;
    chk("x0_nofwd", bus_a.rs1_data, 0);
    tick();
    bus_a.we = 1'b0;
    #1;
    chk("x0_read", bus_a.rs1_data, 0);

    // 3: forwarding vs no forwarding
    bus_a.we = 1'b1; bus_a.rd_addr = 5'd5; bus_a.rd_data = 32'd7;
    tick();
    bus_a.rd_data = 32'd6553; bus_a.rs1_addr = 5'd5;
    #1;
    chk("byp_same", bus_a.rs1_data, 32'd6553);
    chk("nobyp_same", bus_b.rs1_data, 32'd7);
    tick();
    bus_a.we = 1'b0;
    #1;
    chk("byp_after", bus_a.rs1_data, 32'd6553);
    chk("nobyp_after", bus_b.rs1_data, 32'd6553);

    // 4: issue then write-back
    bus_a.issue_valid = 1'b1; bus_a.issue_rd = 5'd3;
    tick();
    bus_a.issue_valid = 1'b0; bus_a.rs1_addr = 5'd3; bus_a.rs2_addr = 5'd2;
    #1;
    chk("iss_busy", 32'(bus_a.rs1_busy), 1);
    chk("iss_busy2", 32'(bus_a.rs2_busy), 0);
    chk("iss_stall", 32'(bus_a.stall), 1);
    chk("iss_cnt", 32'(bus_a.pending_cnt), 1);
    bus_a.we = 1'b1; bus_a.rd_addr = 5'd3; bus_a.rd_data = 32'd288;
    #1;
    chk("wb_busy_byp", 32'(bus_a.rs1_busy), 0);
    chk("wb_stall_byp", 32'(bus_a.stall), 0);
    chk("wb_busy_nobyp", 32'(bus_b.rs1_busy), 1);
    chk("wb_cnt_same", 32'(bus_a.pending_cnt), 1);
    tick();
    bus_a.we = 1'b0;
    #1;
    chk("wb_cnt", 32'(bus_a.pending_cnt), 0);
    chk("wb_busy_after", 32'(bus_b.rs1_busy), 0);
    chk("wb_data", bus_a.rs1_data, 32'd288);

    // 5: set+clear same reg, re-issue, issue to x0
    bus_a.issue_valid = 1'b1; bus_a.issue_rd = 5'd4;
    tick();
    bus_a.we = 1'b1; bus_a.rd_addr = 5'd4; bus_a.rd_data = 32'd9;
    tick();
    bus_a.we = 1'b0; bus_a.issue_valid = 1'b0; bus_a.rs1_addr = 5'd4;
    #1;
    chk("sc_busy", 32'(bus_a.rs1_busy), 1);
    chk("sc_cnt", 32'(bus_a.pending_cnt), 1);
    chk("sc_data", bus_a.rs1_data, 32'd9);
    bus_a.issue_valid = 1'b1; bus_a.issue_rd = 5'd4;
    tick();
    chk("reiss_cnt", 32'(bus_a.pending_cnt), 1);
    bus_a.issue_rd = 5'd0; bus_a.rs2_addr = 5'd0;
    tick();
    bus_a.issue_valid = 1'b0;
    #1;
    chk("iss0_cnt", 32'(bus_a.pending_cnt), 1);
    chk("iss0_busy", 32'(bus_a.rs2_busy), 0);
    bus_a.we = 1'b1; bus_a.rd_addr = 5'd4; bus_a.rd_data = 32'd10;
    tick();
    bus_a.we = 1'b0;
    #1;
    chk("clr4_cnt", 32'(bus_a.pending_cnt), 0);

    // 6: asynchronous reset with pending marks
    bus_a.issue_valid = 1'b1;
    for (int r = 6; r <= 8; r++) begin
      bus_a.issue_rd = 5'(r);
      tick();
    end
    bus_a.issue_valid = 1'b0; bus_a.rs1_addr = 5'd6; bus_a.rs2_addr = 5'd7;
    #1;
    chk("pend3_cnt", 32'(bus_a.pending_cnt), 3);
    chk("pend3_stall", 32'(bus_a.stall), 1);
    rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(bus_a.pending_cnt), 0);
    chk("arst_busy", {30'd0, bus_a.rs1_busy, bus_a.rs2_busy}, 0);
    chk("arst_stall", 32'(bus_a.stall), 0);
    bus_a.rs1_addr = 5'd5; bus_a.rs2_addr = 5'd1;
    bus_a.we = 1'b1; bus_a.rd_addr = 5'd5; bus_a.rd_data = 32'd123;
    #1;
    chk("arst_nofwd", bus_a.rs1_data, 0);
    chk("arst_x1", bus_a.rs2_data, 0);
    tick();
    bus_a.we = 1'b0;
    rst = 1'b0;
    tick();
    #1;
    chk("post_x5", bus_a.rs1_data, 0);
    chk("post_cnt", 32'(bus_a.pending_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
